// File: rtl/pid_pkg.sv
// Types and constants shared across the PID controller slice, including
// the complementary PWM output stage.
package pid_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

  localparam int PWM_PERIOD       = 255;
  localparam int DEFAULT_DEADTIME = 4;

endpackage

// File: rtl/pwm_generator_if.sv
// Control and gate-drive signals between the PID controller and the PWM generator.
interface pwm_generator_if #(
  parameter int PRESCALE_W = 8
);

  logic                  enable;
  logic [7:0]            duty;
  logic                  duty_valid;
  logic [PRESCALE_W-1:0] prescale;
  logic                  pwm_hi;
  logic                  pwm_lo;
  logic                  period_start;

  modport master (
    output enable, duty, duty_valid, prescale,
    input  pwm_hi, pwm_lo, period_start
  );

  modport slave (
    input  enable, duty, duty_valid, prescale,
    output pwm_hi, pwm_lo, period_start
  );

endinterface

// File: rtl/pwm_deadtime.sv
// Turns raw PWM into a non-overlapping high/low gate pair, holding both gates
// off for DEADTIME clocks after every raw transition.
module pwm_deadtime
  import pid_pkg::*;
#(
  parameter int DEADTIME = DEFAULT_DEADTIME
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam int            CW        = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEADTIME);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0] dead_cnt;
  logic          raw_q;
  logic          armed;
  logic          raw_edge;

  // The first running cycle after a clear counts as an edge, so entry gets
  // the same dead interval as any other transition.
  assign raw_edge = !armed || (raw != raw_q);

  // Gates switch on from the cycle where the counter is about to hit zero,
  // which gives exactly DEADTIME off-cycles between the two gates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
      raw_q    <= 1'b0;
      armed    <= 1'b0;
      pwm_hi   <= 1'b0;
      pwm_lo   <= 1'b0;
    end else if (clear) begin
      dead_cnt <= DEAD_LOAD;
      raw_q    <= 1'b0;
      armed    <= 1'b0;
      pwm_hi   <= 1'b0;
      pwm_lo   <= 1'b0;
    end else if (raw_edge) begin
      dead_cnt <= DEAD_LOAD;
      raw_q    <= raw;
      armed    <= 1'b1;
      pwm_hi   <= (DEADTIME == 0) && raw;
      pwm_lo   <= (DEADTIME == 0) && !raw;
    end else begin
      if (dead_cnt != '0) begin
        dead_cnt <= dead_cnt - ONE;
      end
      pwm_hi <= (dead_cnt <= ONE) && raw;
      pwm_lo <= (dead_cnt <= ONE) && !raw;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Converts the PID control word into complementary PWM gates with a prescaled
// 255-tick period and duty double-buffered to period boundaries.
module pwm_generator
  import pid_pkg::*;
#(
  parameter int DEADTIME   = DEFAULT_DEADTIME,
  parameter int PRESCALE_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  pwm_generator_if.slave bus
);

  localparam logic [7:0] LAST_COUNT = 8'(PWM_PERIOD - 1);

  pwm_state_t            state;
  pwm_state_t            next_state;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [7:0]            period_cnt;
  logic [7:0]            shadow;
  logic [7:0]            active;
  logic [7:0]            load_duty;
  logic                  tick;
  logic                  wrap;
  logic                  raw;
  logic                  clear;
  logic                  period_start;
  logic                  gate_hi;
  logic                  gate_lo;

  // A strobe on a load cycle bypasses the shadow so the new value is not lost.
  assign load_duty = bus.duty_valid ? bus.duty : shadow;
  assign tick      = (state == RUN) && (presc_cnt == bus.prescale);
  assign wrap      = tick && (period_cnt == LAST_COUNT);
  assign raw       = (state == RUN) && (period_cnt < active);
  assign clear     = (state != RUN) || !bus.enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.enable)  next_state = RUN;
      RUN:     if (!bus.enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (bus.duty_valid) begin
      shadow <= bus.duty;
    end
  end

  // Disabling drops everything on the next edge; no drain to the period end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt    <= '0;
      period_cnt   <= '0;
      active       <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      if (next_state == IDLE) begin
        presc_cnt  <= '0;
        period_cnt <= '0;
      end else if (state == IDLE) begin
        presc_cnt    <= '0;
        period_cnt   <= '0;
        active       <= load_duty;
        period_start <= 1'b1;
      end else begin
        presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
        if (tick) begin
          period_cnt <= wrap ? '0 : period_cnt + 8'd1;
        end
        if (wrap) begin
          active       <= load_duty;
          period_start <= 1'b1;
        end
      end
    end
  end

  pwm_deadtime #(
    .DEADTIME(DEADTIME)
  ) u_deadtime (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .raw    (raw),
    .pwm_hi (gate_hi),
    .pwm_lo (gate_lo)
  );

  assign bus.pwm_hi       = gate_hi;
  assign bus.pwm_lo       = gate_lo;
  assign bus.period_start = period_start;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: one instance without dead-time and one
// with DEADTIME=4, driven identically.
module tb_pwm_generator;

  logic clk = 1'b0;
  logic rst_n;
  int   vec_count        = 0;
  int   miscompare_count = 0;
  int   overlap_count    = 0;

  pwm_generator_if #(.PRESCALE_W(8)) bus0 ();
  pwm_generator_if #(.PRESCALE_W(8)) bus4 ();

  pwm_generator #(.DEADTIME(0), .PRESCALE_W(8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  pwm_generator #(.DEADTIME(4), .PRESCALE_W(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((bus0.pwm_hi && bus0.pwm_lo) || (bus4.pwm_hi && bus4.pwm_lo)) overlap_count++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] d, input logic dv, input logic [7:0] ps);
    bus0.enable = en; bus0.duty = d; bus0.duty_valid = dv; bus0.prescale = ps;
    bus4.enable = en; bus4.duty = d; bus4.duty_valid = dv; bus4.prescale = ps;
  endtask

  task automatic setEnable(input logic en);
    bus0.enable = en;
    bus4.enable = en;
  endtask

  task automatic strobeDuty(input logic [7:0] d);
    bus0.duty = d; bus0.duty_valid = 1'b1;
    bus4.duty = d; bus4.duty_valid = 1'b1;
    stepCycle();
    bus0.duty_valid = 1'b0;
    bus4.duty_valid = 1'b0;
  endtask

  task automatic waitPeriodStart(input string tag, input int budget);
    int n = 0;
    do begin
      stepCycle();
      n++;
    end while (!bus0.period_start && n < budget);
    checkOutput(tag, bus0.period_start, 1);
  endtask

  // Samples n cycles; sample i reflects the period count i-1 when started on a pulse.
  task automatic measureWindow(input int n, input int strobe_at, input logic [7:0] strobe_val,
                               output int hi0, output int lo0, output int hi4, output int lo4,
                               output int ps_count, output int ps_pos);
    hi0 = 0; lo0 = 0; hi4 = 0; lo4 = 0; ps_count = 0; ps_pos = 0;
    for (int i = 1; i <= n; i++) begin
      if (i - 1 == strobe_at) begin
        bus0.duty = strobe_val; bus0.duty_valid = 1'b1;
        bus4.duty = strobe_val; bus4.duty_valid = 1'b1;
      end else begin
        bus0.duty_valid = 1'b0;
        bus4.duty_valid = 1'b0;
      end
      stepCycle();
      hi0 += int'(bus0.pwm_hi);
      lo0 += int'(bus0.pwm_lo);
      hi4 += int'(bus4.pwm_hi);
      lo4 += int'(bus4.pwm_lo);
      if (bus0.period_start) begin
        ps_count++;
        ps_pos = i;
      end
    end
    bus0.duty_valid = 1'b0;
    bus4.duty_valid = 1'b0;
  endtask

  initial begin
    int hi0, lo0, hi4, lo4, psc, psp;
    int run_len, gaps, any_on;

    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    repeat (3) stepCycle();
    checkOutput("reset_hi0", bus0.pwm_hi, 0);
    checkOutput("reset_lo0", bus0.pwm_lo, 0);
    checkOutput("reset_ps0", bus0.period_start, 0);
    checkOutput("reset_hi4", bus4.pwm_hi, 0);
    checkOutput("reset_lo4", bus4.pwm_lo, 0);
    rst_n = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] test 1: duty 128, no dead-time");
    applyStimulus(1'b1, 8'd128, 1'b1, 8'd0);
    stepCycle();
    applyStimulus(1'b1, 8'd128, 1'b0, 8'd0);
    checkOutput("t1_entry_pulse", bus0.period_start, 1);
    for (int p = 0; p < 2; p++) begin
      measureWindow(255, -1, 8'd0, hi0, lo0, hi4, lo4, psc, psp);
      checkOutput("t1_hi_count", hi0, 128);
      checkOutput("t1_lo_count", lo0, 127);
      checkOutput("t1_ps_count", psc, 1);
      checkOutput("t1_ps_pos", psp, 255);
    end

    $display("[TB] test 2: duty 0 then 255, dead-time 4");
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    repeat (3) stepCycle();
    checkOutput("t2_idle_gates", int'(bus4.pwm_hi | bus4.pwm_lo), 0);
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd0);
    stepCycle();
    applyStimulus(1'b1, 8'd0, 1'b0, 8'd0);
    checkOutput("t2_entry_pulse", bus4.period_start, 1);
    any_on = 0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      any_on |= int'(bus4.pwm_hi | bus4.pwm_lo);
    end
    checkOutput("t2_entry_dead", any_on, 0);
    stepCycle();
    checkOutput("t2_lo_on", bus4.pwm_lo, 1);
    measureWindow(300, -1, 8'd0, hi0, lo0, hi4, lo4, psc, psp);
    checkOutput("t2_duty0_hi", hi4, 0);
    checkOutput("t2_duty0_lo", lo4, 300);
    strobeDuty(8'd255);
    waitPeriodStart("t2_wrap", 300);
    repeat (6) stepCycle();
    measureWindow(300, -1, 8'd0, hi0, lo0, hi4, lo4, psc, psp);
    checkOutput("t2_duty255_hi", hi4, 300);
    checkOutput("t2_duty255_lo", lo4, 0);

    $display("[TB] test 3: double-buffered duty updates");
    strobeDuty(8'd200);
    waitPeriodStart("t3_sync", 300);
    measureWindow(255, 100, 8'd50, hi0, lo0, hi4, lo4, psc, psp);
    checkOutput("t3_old_duty_hi", hi0, 200);
    checkOutput("t3_old_ps_pos", psp, 255);
    measureWindow(255, 254, 8'd30, hi0, lo0, hi4, lo4, psc, psp);
    checkOutput("t3_new_duty_hi", hi0, 50);
    measureWindow(255, -1, 8'd0, hi0, lo0, hi4, lo4, psc, psp);
    checkOutput("t3_wrap_strobe_hi", hi0, 30);

    $display("[TB] test 4: dead-time gaps at duty 100");
    strobeDuty(8'd100);
    waitPeriodStart("t4_sync", 300);
    run_len = 0;
    gaps    = 0;
    for (int i = 0; i < 510; i++) begin
      stepCycle();
      if (!bus4.pwm_hi && !bus4.pwm_lo) begin
        run_len++;
      end else if (run_len > 0) begin
        checkOutput("t4_dead_gap", run_len, 4);
        gaps++;
        run_len = 0;
      end
    end
    checkOutput("t4_gap_count", gaps, 4);

    $display("[TB] test 5: prescale 3, duty 64");
    applyStimulus(1'b1, 8'd100, 1'b0, 8'd3);
    strobeDuty(8'd64);
    waitPeriodStart("t5_sync", 1200);
    measureWindow(1020, -1, 8'd0, hi0, lo0, hi4, lo4, psc, psp);
    checkOutput("t5_hi_count", hi0, 256);
    checkOutput("t5_ps_count", psc, 1);
    checkOutput("t5_ps_pos", psp, 1020);

    $display("[TB] test 6: disable and async reset mid-period");
    applyStimulus(1'b1, 8'd100, 1'b0, 8'd0);
    strobeDuty(8'd100);
    waitPeriodStart("t6_sync", 1200);
    repeat (30) stepCycle();
    checkOutput("t6_pre_disable_hi", bus0.pwm_hi, 1);
    setEnable(1'b0);
    stepCycle();
    checkOutput("t6_disable_gates", int'(bus0.pwm_hi | bus0.pwm_lo | bus4.pwm_hi | bus4.pwm_lo), 0);
    repeat (2) stepCycle();
    setEnable(1'b1);
    stepCycle();
    checkOutput("t6_reenable_pulse", bus0.period_start, 1);
    measureWindow(255, -1, 8'd0, hi0, lo0, hi4, lo4, psc, psp);
    checkOutput("t6_restart_hi", hi0, 100);
    checkOutput("t6_restart_ps_pos", psp, 255);
    repeat (50) stepCycle();
    checkOutput("t6_pre_reset_hi", bus0.pwm_hi, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_reset_gates", int'(bus0.pwm_hi | bus0.pwm_lo | bus4.pwm_hi | bus4.pwm_lo), 0);
    checkOutput("t6_reset_ps", int'(bus0.period_start | bus4.period_start), 0);
    repeat (2) stepCycle();
    #2;
    rst_n = 1'b1;
    stepCycle();
    checkOutput("t6_reset_restart", bus0.period_start, 1);

    checkOutput("overlap", overlap_count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
